// File: rtl/asym_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module      : asym_pingpong_ram
// Description : Double-buffered frame store. Narrow 8-bit write port fills
//               the back bank, wide LANES x 8-bit read port scans the front
//               bank. Banks swap only on a frame-sync boundary. A clear
//               engine fills the back bank with CLEAR_BYTE, one word per
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module asym_pingpong_ram #(
    parameter int           LANES      = 4,
    parameter int           AW         = 9,
    parameter logic [7:0]   CLEAR_BYTE = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [AW+$clog2(LANES)-1:0]   wr_addr,
    input  logic [7:0]                    wr_data,
    input  logic                          rd_en,
    input  logic [AW-1:0]                 rd_addr,
    output logic [8*LANES-1:0]            rd_data,
    output logic                          rd_valid,
    input  logic                          swap_req,
    input  logic                          frame_sync,
    output logic                          swap_ack,
    output logic                          front_bank,
    input  logic                          clear_req,
    output logic                          busy
);

    localparam int LB    = $clog2(LANES);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic            r_pending;
    logic            w_pending_next;
    logic            w_swap_fire;

    logic            w_clear_we;
    logic            w_byte_we;
    logic [LB-1:0]   w_lane_sel;
    logic [AW:0]     w_waddr;
    logic [7:0]      w_wbyte;
    logic [AW:0]     w_raddr;

    // Control state: FSM state, clear counter and pending-swap flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
        end
    end

    // Next-state logic for the clear engine and the swap arbitration
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        w_swap_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == {AW{1'b1}}) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Swaps are held off while clearing so the bank being cleared never
        // becomes visible half-done; the request stays pending instead.
        w_swap_fire = frame_sync & (r_pending | swap_req) & (r_state == ST_IDLE);
        if (w_swap_fire) begin
            w_pending_next = 1'b0;
        end else if (swap_req) begin
            w_pending_next = 1'b1;
        end
    end

    // Registered status outputs: bank select, swap acknowledge, busy, valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_bank <= 1'b0;
            swap_ack   <= 1'b0;
            busy       <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            front_bank <= front_bank ^ w_swap_fire;
            swap_ack   <= w_swap_fire;
            busy       <= (w_state_next == ST_CLEAR);
            rd_valid   <= rd_en;
        end
    end

    // Write side always targets the back bank using the pre-edge bank index,
    // so a write coinciding with a swap lands in the bank about to be shown.
    assign w_clear_we = (r_state == ST_CLEAR);
    assign w_byte_we  = wr_en & (r_state == ST_IDLE);
    assign w_lane_sel = wr_addr[LB-1:0];
    assign w_waddr    = {~front_bank, (w_clear_we ? r_cnt : wr_addr[AW+LB-1:LB])};
    assign w_wbyte    = w_clear_we ? CLEAR_BYTE : wr_data;
    assign w_raddr    = {front_bank, rd_addr};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] mem [0:2*DEPTH-1];
        logic       w_we;
        logic [7:0] r_rd_byte;

        assign w_we = w_clear_we | (w_byte_we & (w_lane_sel == LB'(k)));

        // Byte-lane storage for both banks; contents are never reset
        always_ff @(posedge clk) begin
            if (w_we) begin
                mem[w_waddr] <= w_wbyte;
            end
        end

        // Registered read of this lane from the front bank; holds without rd_en
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rd_byte <= 8'h00;
            end else if (rd_en) begin
                r_rd_byte <= mem[w_raddr];
            end
        end

        assign rd_data[8*k +: 8] = r_rd_byte;
    end

endmodule
`default_nettype wire

// File: tb/tb_asym_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_asym_pingpong_ram
// Description : Directed self-checking bench for asym_pingpong_ram
//               (LANES=4, AW=9, CLEAR_BYTE=8'h00).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asym_pingpong_ram;

    localparam int LANES = 4;
    localparam int AW    = 9;
    localparam int DEPTH = 2 ** AW;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        swap_req;
    logic        frame_sync;
    logic        swap_ack;
    logic        front_bank;
    logic        clear_req;
    logic        busy;

    int checks = 0;
    int errors = 0;

    asym_pingpong_ram #(
        .LANES      (LANES),
        .AW         (AW),
        .CLEAR_BYTE (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .swap_req   (swap_req),
        .frame_sync (frame_sync),
        .swap_ack   (swap_ack),
        .front_bank (front_bank),
        .clear_req  (clear_req),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [10:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_swap(input logic exp_front);
        swap_req = 1'b1;
        tick();
        swap_req   = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("swap_ack_hi", {31'd0, swap_ack}, 32'd1);
        check("front_after_swap", {31'd0, front_bank}, {31'd0, exp_front});
        tick();
        check("swap_ack_lo", {31'd0, swap_ack}, 32'd0);
    endtask

    task automatic read_word(input string tag, input logic [8:0] a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, rd_data, exp);
        tick();
        check({tag, "_valid_lo"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_hold"}, rd_data, exp);
    endtask

    initial begin
        int cyc;
        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        swap_req   = 1'b0;
        frame_sync = 1'b0;
        clear_req  = 1'b0;

        // Reset values
        #12;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_swap_ack", {31'd0, swap_ack}, 32'd0);
        check("rst_front", {31'd0, front_bank}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // frame_sync with nothing pending does nothing
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("fs_nopend_ack", {31'd0, swap_ack}, 32'd0);
        check("fs_nopend_front", {31'd0, front_bank}, 32'd0);

        // Fill bank 1 word 0, swap, read back
        write_byte(11'd0, 8'h11);
        write_byte(11'd1, 8'h22);
        write_byte(11'd2, 8'h33);
        write_byte(11'd3, 8'h44);
        do_swap(1'b1);
        read_word("word0_b1", 9'd0, 32'h44332211);

        // Bank 0 word 1 full write, then bank 1 word 1 full write
        write_byte(11'd4, 8'h55);
        write_byte(11'd5, 8'h66);
        write_byte(11'd6, 8'h77);
        write_byte(11'd7, 8'h88);
        do_swap(1'b0);
        read_word("word1_b0", 9'd1, 32'h88776655);
        write_byte(11'd4, 8'h01);
        write_byte(11'd5, 8'h02);
        write_byte(11'd6, 8'h03);
        write_byte(11'd7, 8'h04);
        do_swap(1'b1);
        read_word("word1_b1", 9'd1, 32'h04030201);

        // Partial lane write into bank 0 word 1 lane 2
        write_byte(11'd6, 8'hAA);
        do_swap(1'b0);
        read_word("partial_lane", 9'd1, 32'h88AA6655);

        // Clear bank 1 with a dropped write and a deferred swap inside
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (busy && cyc < 600) begin
            cyc++;
            wr_en      = (cyc == 10);
            wr_addr    = 11'd4;
            wr_data    = 8'h5A;
            swap_req   = (cyc == 50);
            frame_sync = (cyc == 100);
            tick();
            if (cyc == 100) begin
                check("clr_fs_no_ack", {31'd0, swap_ack}, 32'd0);
                check("clr_fs_no_toggle", {31'd0, front_bank}, 32'd0);
            end
        end
        wr_en      = 1'b0;
        swap_req   = 1'b0;
        frame_sync = 1'b0;
        check("busy_cycles", cyc, DEPTH);

        // Pending swap honoured at first frame_sync after clear
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("deferred_ack", {31'd0, swap_ack}, 32'd1);
        check("deferred_front", {31'd0, front_bank}, 32'd1);

        // Pipelined scan of whole cleared bank
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 9'(i);
            tick();
            check("clr_valid", {31'd0, rd_valid}, 32'd1);
            check("clr_word", rd_data, 32'h0);
        end
        rd_en = 1'b0;
        tick();

        // Swap-edge collision on word 5 (back bank 0 pre-filled on lanes 1..3)
        write_byte(11'd21, 8'hB1);
        write_byte(11'd22, 8'hB2);
        write_byte(11'd23, 8'hB3);
        swap_req = 1'b1;
        tick();
        swap_req   = 1'b0;
        frame_sync = 1'b1;
        rd_en      = 1'b1;
        rd_addr    = 9'd5;
        wr_en      = 1'b1;
        wr_addr    = 11'd20;
        wr_data    = 8'h77;
        tick();
        frame_sync = 1'b0;
        wr_en      = 1'b0;
        check("coll_old_front", rd_data, 32'h0);
        check("coll_ack", {31'd0, swap_ack}, 32'd1);
        check("coll_front", {31'd0, front_bank}, 32'd0);
        tick();
        rd_en = 1'b0;
        check("coll_new_front", rd_data, 32'hB3B2B177);

        // Reset during clear with a pending swap
        do_swap(1'b1);
        clear_req = 1'b1;
        swap_req  = 1'b1;
        tick();
        clear_req = 1'b0;
        swap_req  = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = 9'd0;
        repeat (20) tick();
        rd_en = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rd_data", rd_data, 32'h0);
        check("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_front", {31'd0, front_bank}, 32'd0);
        check("arst_swap_ack", {31'd0, swap_ack}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("post_rst_no_ack", {31'd0, swap_ack}, 32'd0);
        check("post_rst_front", {31'd0, front_bank}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
